mem_port_arbiter: RTL and testbench

Shares the single memory bus between the instruction-cache miss path and the data-cache miss/writeback path. Arbitrates between the two requesters with round-robin fairness and sequences each winner through a fixed-length burst. It produces the `busy` indication consumed by hazard detection for fetch stalling. It sits between the two caches and the memory model.

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of cache-side and memory-side signals shared by the memory port arbiter.
// The master modport is the arbiter's view; slave is the caches plus memory model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_cancel;
  logic              i_grant;
  logic              i_data_valid;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_grant;
  logic              d_wnext;
  logic              d_data_valid;
  logic              d_done;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wready;

  modport master (
    input  i_req, i_addr, i_cancel,
    output i_grant, i_data_valid, i_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_grant, d_wnext, d_data_valid, d_done,
    output rdata, busy,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rvalid, mem_rdata, mem_wready
  );

  modport slave (
    output i_req, i_addr, i_cancel,
    input  i_grant, i_data_valid, i_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_grant, d_wnext, d_data_valid, d_done,
    input  rdata, busy,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rvalid, mem_rdata, mem_wready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lends the single memory bus to the I-cache fill path or the
// D-cache fill/writeback path and walks the winner through a fixed-length burst.
module mem_port_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.master bus
);

  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int STRIDE = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, REQ, BEAT, DONE} state_t;

  state_t            state, state_next;
  logic              owner_d, owner_d_next;
  logic              last_d, last_d_next;
  logic              we, we_next;
  logic              kill, kill_next;
  logic [ADDR_W-1:0] base, base_next;
  logic [CNT_W-1:0]  count, count_next;

  logic i_eligible;
  logic win_d;
  logic beat;
  logic active;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      last_d  <= 1'b0;
      we      <= 1'b0;
      kill    <= 1'b0;
      base    <= '0;
      count   <= '0;
    end else begin
      state   <= state_next;
      owner_d <= owner_d_next;
      last_d  <= last_d_next;
      we      <= we_next;
      kill    <= kill_next;
      base    <= base_next;
      count   <= count_next;
    end
  end

  always_comb begin
    state_next   = state;
    owner_d_next = owner_d;
    last_d_next  = last_d;
    we_next      = we;
    kill_next    = kill;
    base_next    = base;
    count_next   = count;

    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;

    // A cancelled fetch never competes; on a tie the side not served last wins.
    i_eligible = bus.i_req & ~bus.i_cancel;
    win_d      = bus.d_req & (~i_eligible | ~last_d);
    beat       = (state == BEAT) & (we ? bus.mem_wready : bus.mem_rvalid);
    active     = (state == REQ) | (state == BEAT);

    case (state)
      IDLE: begin
        if (i_eligible | bus.d_req) begin
          owner_d_next = win_d;
          we_next      = win_d & bus.d_we;
          base_next    = win_d ? bus.d_addr : bus.i_addr;
          count_next   = '0;
          kill_next    = 1'b0;
          state_next   = REQ;
        end
      end
      REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = base;
        if (bus.mem_ack) state_next = BEAT;
      end
      BEAT: begin
        bus.mem_addr = base + ADDR_W'(count) * ADDR_W'(STRIDE);
        if (beat) begin
          count_next = count + CNT_W'(1);
          if (count == CNT_W'(BURST_LEN - 1)) state_next = DONE;
        end
      end
      DONE: begin
        last_d_next = owner_d;
        kill_next   = 1'b0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Memory cannot abort a burst, so a redirect only hides the rest of the I fill.
    if (active & ~owner_d & bus.i_cancel) kill_next = 1'b1;

    bus.mem_we       = active & we;
    bus.mem_wdata    = (active & we) ? bus.d_wdata : '0;
    bus.busy         = (state != IDLE);
    bus.i_grant      = (state != IDLE) & ~owner_d;
    bus.d_grant      = (state != IDLE) & owner_d;
    bus.i_data_valid = beat & ~we & ~owner_d & ~kill;
    bus.d_data_valid = beat & ~we & owner_d;
    bus.d_wnext      = beat & we;
    bus.i_done       = (state == DONE) & ~owner_d & ~kill;
    bus.d_done       = (state == DONE) & owner_d;
  end

  assign bus.rdata = reset ? '0 : bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 64;
  localparam int BURST_LEN = 8;
  localparam int STRIDE    = DATA_W / 8;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: a transaction is in flight from grant until its done cycle.
  bit          m_busy, m_owner_d, m_we, m_acked, m_killed, m_last_d;
  logic [63:0] m_base;
  int          m_beats;

  int          cyc, n_i_dv, n_d_dv, n_wnext, n_i_done, n_d_done, n_busy, i_done_cyc;
  bit          saw_i_done, saw_d_done, prev_grant;
  bit          grant_log[$];
  logic [63:0] addr_log[$];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  always @(posedge clk or posedge reset) begin : model
    bit i_ok;
    i_ok = bus.i_req && !bus.i_cancel;
    if (reset) begin
      m_busy = 0; m_owner_d = 0; m_we = 0; m_acked = 0; m_killed = 0; m_last_d = 0;
      m_base = '0; m_beats = 0;
    end else if (!m_busy) begin
      if (i_ok || bus.d_req) begin
        m_owner_d = bus.d_req && (!i_ok || !m_last_d);
        m_we      = m_owner_d && bus.d_we;
        m_base    = m_owner_d ? bus.d_addr : bus.i_addr;
        m_busy    = 1; m_acked = 0; m_beats = 0; m_killed = 0;
      end
    end else if (!m_acked) begin
      if (bus.mem_ack) m_acked = 1;
      if (!m_owner_d && bus.i_cancel) m_killed = 1;
    end else if (m_beats < BURST_LEN) begin
      if (m_we ? bus.mem_wready : bus.mem_rvalid) m_beats++;
      if (!m_owner_d && bus.i_cancel) m_killed = 1;
    end else begin
      m_busy = 0; m_last_d = m_owner_d; m_killed = 0;
    end
  end

  task automatic checkAll();
    bit req_ph, beat_ph, done_ph, rd, wr, act;
    logic [63:0] e_addr;
    req_ph  = m_busy && !m_acked;
    beat_ph = m_busy && m_acked && (m_beats < BURST_LEN);
    done_ph = m_busy && m_acked && (m_beats == BURST_LEN);
    rd      = beat_ph && !m_we && bus.mem_rvalid;
    wr      = beat_ph && m_we && bus.mem_wready;
    act     = req_ph || beat_ph;
    e_addr  = req_ph ? m_base : (beat_ph ? m_base + 64'(m_beats) * 64'(STRIDE) : 64'h0);
    checkOutput("busy",         bus.busy,         m_busy);
    checkOutput("i_grant",      bus.i_grant,      m_busy && !m_owner_d);
    checkOutput("d_grant",      bus.d_grant,      m_busy && m_owner_d);
    checkOutput("mem_req",      bus.mem_req,      req_ph);
    checkOutput("mem_addr",     bus.mem_addr,     e_addr);
    checkOutput("mem_we",       bus.mem_we,       act && m_we);
    checkOutput("mem_wdata",    bus.mem_wdata,    (act && m_we) ? bus.d_wdata : 64'h0);
    checkOutput("i_data_valid", bus.i_data_valid, rd && !m_owner_d && !m_killed);
    checkOutput("d_data_valid", bus.d_data_valid, rd && m_owner_d);
    checkOutput("d_wnext",      bus.d_wnext,      wr);
    checkOutput("i_done",       bus.i_done,       done_ph && !m_owner_d && !m_killed);
    checkOutput("d_done",       bus.d_done,       done_ph && m_owner_d);
    checkOutput("rdata",        bus.rdata,        reset ? 64'h0 : bus.mem_rdata);
  endtask

  task automatic clearObs();
    cyc = 0; n_i_dv = 0; n_d_dv = 0; n_wnext = 0; n_i_done = 0; n_d_done = 0; n_busy = 0;
    i_done_cyc = -1; saw_i_done = 0; saw_d_done = 0;
    grant_log.delete(); addr_log.delete();
  endtask

  // One clock cycle: drive memory-side inputs, compare outputs, log events.
  task automatic applyStimulus(input bit ack, input bit rvalid, input bit wready);
    bit g;
    bus.mem_ack    = ack;
    bus.mem_rvalid = rvalid;
    bus.mem_wready = wready;
    bus.mem_rdata  = {$urandom, $urandom};
    bus.d_wdata    = {$urandom, $urandom};
    #1;
    checkAll();
    if (bus.i_data_valid) n_i_dv++;
    if (bus.d_data_valid) n_d_dv++;
    if (bus.d_wnext)      n_wnext++;
    if (bus.busy)         n_busy++;
    if (bus.i_done) begin n_i_done++; i_done_cyc = cyc; end
    if (bus.d_done) n_d_done++;
    saw_i_done = bus.i_done;
    saw_d_done = bus.d_done;
    g = bus.i_grant || bus.d_grant;
    if (g && !prev_grant) grant_log.push_back(bus.d_grant);
    prev_grant = g;
    if (bus.i_data_valid || bus.d_data_valid || bus.d_wnext) addr_log.push_back(bus.mem_addr);
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [63:0] randLine();
    if ($urandom_range(7) == 0) return {32'hFFFF_FFFF, $urandom} & ~64'h3F;
    return {$urandom, $urandom} & ~64'h3F;
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] wrap_exp [4];
    bit cancel_prev;
    wrap_exp = '{64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8};

    bus.i_req = 0; bus.i_addr = '0; bus.i_cancel = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.mem_wready = 0;
    prev_grant = 0;
    clearObs();
    reset = 1;
    @(negedge clk);
    bus.mem_rdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    checkOutput("rst_busy",    bus.busy,    0);
    checkOutput("rst_mem_req", bus.mem_req, 0);
    checkOutput("rst_rdata",   bus.rdata,   0);
    applyStimulus(0, 0, 0);
    reset = 0;
    applyStimulus(0, 0, 0);

    $display("[TB] lone I fill");
    clearObs();
    bus.i_req = 1; bus.i_addr = 64'h1000;
    for (int c = 0; c < 13; c++) begin
      if (saw_i_done) bus.i_req = 0;
      applyStimulus(1, 1, 0);
    end
    bus.i_req = 0;
    checkOutput("t1_beats",     n_i_dv,     8);
    checkOutput("t1_done_cyc",  i_done_cyc, 10);
    checkOutput("t1_busy_cyc",  n_busy,     10);
    checkOutput("t1_addr_cnt",  addr_log.size(), 8);
    for (int i = 0; i < addr_log.size() && i < 8; i++)
      checkOutput("t1_addr", addr_log[i], 64'h1000 + 64'(i * STRIDE));

    $display("[TB] tie after reset, both held");
    reset = 1; applyStimulus(0, 0, 0); reset = 0;
    clearObs();
    bus.i_req = 1; bus.i_addr = 64'h2000; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h3000;
    for (int c = 0; c < 48; c++) applyStimulus(1, 1, 0);
    bus.i_req = 0; bus.d_req = 0;
    for (int c = 0; c < 12; c++) applyStimulus(1, 1, 0);
    checkOutput("t2_grants", grant_log.size() >= 4, 1);
    for (int k = 0; k < grant_log.size() && k < 4; k++)
      checkOutput("t2_order", grant_log[k], (k % 2) == 0);

    $display("[TB] D writeback, wready alternate");
    clearObs();
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 64'h4000;
    for (int c = 0; c < 40; c++) begin
      if (saw_d_done) bus.d_req = 0;
      applyStimulus(1, 1, (c % 2) == 1);
    end
    bus.d_req = 0; bus.d_we = 0;
    checkOutput("t3_wnext", n_wnext,  8);
    checkOutput("t3_done",  n_d_done, 1);
    checkOutput("t3_rdv",   n_d_dv,   0);

    $display("[TB] I cancel after beat 3");
    clearObs();
    bus.i_req = 1; bus.i_addr = 64'h5000;
    for (int c = 0; c < 32; c++) begin
      bus.i_cancel = (c == 5);
      if (c == 6) bus.i_req = 0;
      if (saw_d_done) bus.d_req = 0;
      if (c == 5) begin bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h6000; end
      applyStimulus(1, c != 5, 0);
    end
    bus.i_cancel = 0; bus.d_req = 0;
    checkOutput("t4_i_beats", n_i_dv,   3);
    checkOutput("t4_i_done",  n_i_done, 0);
    checkOutput("t4_d_beats", n_d_dv,   8);
    checkOutput("t4_grants",  grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      checkOutput("t4_first",  grant_log[0], 0);
      checkOutput("t4_second", grant_log[1], 1);
    end

    $display("[TB] address wrap");
    clearObs();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int c = 0; c < 14; c++) begin
      if (saw_d_done) bus.d_req = 0;
      applyStimulus(1, 1, 0);
    end
    bus.d_req = 0;
    checkOutput("t5_addr_cnt", addr_log.size(), 8);
    for (int i = 0; i < addr_log.size() && i < 4; i++)
      checkOutput("t5_wrap", addr_log[i], wrap_exp[i]);

    $display("[TB] reset mid-burst");
    clearObs();
    bus.i_req = 1; bus.i_addr = 64'h7000;
    for (int c = 0; c < 6; c++) applyStimulus(1, 1, 0);
    bus.mem_rvalid = 1; bus.mem_rdata = 64'hDEAD_BEEF_0123_4567;
    reset = 1;
    #1;
    checkOutput("t6_busy",    bus.busy,         0);
    checkOutput("t6_grant",   bus.i_grant,      0);
    checkOutput("t6_mem_req", bus.mem_req,      0);
    checkOutput("t6_dv",      bus.i_data_valid, 0);
    checkOutput("t6_addr",    bus.mem_addr,     0);
    checkOutput("t6_rdata",   bus.rdata,        0);
    applyStimulus(1, 1, 0);
    reset = 0; bus.i_req = 0;
    applyStimulus(1, 1, 0);
    checkOutput("t6_stray", n_i_dv, 4);
    grant_log.delete();
    bus.i_req = 1; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 64'h8000;
    for (int c = 0; c < 14; c++) begin
      if (saw_d_done) bus.d_req = 0;
      if (saw_i_done) bus.i_req = 0;
      applyStimulus(1, 1, 0);
    end
    checkOutput("t6_tie", (grant_log.size() > 0) ? grant_log[0] : 1'b0, 1);
    bus.i_req = 0; bus.d_req = 0;
    for (int c = 0; c < 14; c++) applyStimulus(1, 1, 0);

    $display("[TB] random traffic");
    clearObs();
    for (int c = 0; c < 3000; c++) begin
      cancel_prev = bus.i_cancel;
      if (saw_i_done || cancel_prev) bus.i_req = 0;
      if (saw_d_done) bus.d_req = 0;
      if (!bus.i_req && $urandom_range(3) == 0) begin bus.i_req = 1; bus.i_addr = randLine(); end
      bus.i_cancel = bus.i_req && ($urandom_range(19) == 0);
      if (!bus.d_req && $urandom_range(3) == 0) begin
        bus.d_req = 1; bus.d_we = 1'($urandom_range(1)); bus.d_addr = randLine();
      end
      reset = ($urandom_range(599) == 0);
      applyStimulus($urandom_range(2) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    reset = 0;
    checkOutput("rand_activity", (n_i_dv + n_d_dv + n_wnext) > 0, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
